reg_debug_scan_ctrl: RTL and testbench
======================================

// Module: reg_debug_scan_ctrl
// PURPOSE
//  Sequences the register file's debug read port for the board display.
//  Two sources compete for the port:
//   - manual: the 5-bit register-select switches.
//   - auto: a self-advancing scan over r0..r31, also steppable by a push button.
//  Issues one read at a time and captures the result into a stable display
//  latch. Refreshes periodically so the displayed value tracks the running
//  pipeline. Sits between the board I/O and the register file debug port.
// PARAMETERS
//  REFRESH_CYCLES   1_000_000    manual mode: HOLD cycles before re-reading the same register
//  DWELL_CYCLES     50_000_000   auto mode: HOLD cycles before advancing to the next register
//  DEBOUNCE_CYCLES  1_000_000    consecutive high cycles on step_btn that count as one press
//  SKIP_R0          0            1: auto scan wraps 31->1 and never shows r0
// PORTS
//  clk              in   1   system clock
//  reset            in   1   synchronous, active-high
//  switch_register  in   5   manual register select (already synchronised)
//  mode_auto        in   1   0 = manual, 1 = auto scan (level)
//  step_btn         in   1   raw push button, synchronised but not debounced
//  rf_dbg_addr      out  5   register file debug read address (registered)
//  rf_dbg_data      in   32  register file debug read data
//  disp_addr        out  5   index of the register currently displayed
//  disp_value       out  32  captured value of disp_addr
//  disp_valid       out  1   1 once at least one capture has completed since reset
// BEHAVIOUR
//  Clock and reset: one clock; reset is synchronous and active-high.
//  Reset values:
//   - rf_dbg_addr=0, disp_addr=0, disp_value=0, disp_valid=0.
//   - scan_addr=0 (0 or 1 per SKIP_R0), state=IDLE, all counters 0.
//  FSM states: IDLE, ISSUE, CAPTURE, HOLD.
//  IDLE -> ISSUE on the next edge. On that edge rf_dbg_addr <= target.
//   - manual: target = switch_register.
//   - auto: target = scan_addr.
//  ISSUE -> CAPTURE unconditionally. This gives one full cycle of stable
//   address, so both combinational and 1-cycle synchronous reads work.
//  CAPTURE -> HOLD. On that edge:
//   - disp_value <= rf_dbg_data
//   - disp_addr <= rf_dbg_addr
//   - disp_valid <= 1
//   - hold_cnt <= 0
//  HOLD: hold_cnt increments every cycle. Exit conditions, highest priority first:
//   1. mode_auto differs from the mode captured at the last ISSUE -> ISSUE.
//      On entry to auto, scan_addr <= switch_register, so the scan starts at
//      the selected register.
//   2. manual and switch_register != disp_addr -> ISSUE with the new address.
//   3. auto and a debounced press -> scan_addr advances, then ISSUE.
//   4. hold_cnt == REFRESH_CYCLES-1 (manual) or DWELL_CYCLES-1 (auto) -> ISSUE.
//      Auto advances scan_addr first; manual re-reads the same register.
//  Scan advance: scan_addr+1 mod 32. With SKIP_R0=1, 31 wraps to 1.
//  Latency: a switch change seen in HOLD at edge E updates disp_value at E+2.
//  Switch changes during ISSUE/CAPTURE:
//   - The in-flight read completes with the old address.
//   - The next HOLD cycle detects the mismatch.
//  Debounce:
//   - db_cnt counts consecutive step_btn=1 cycles; it clears whenever step_btn=0.
//   - Exactly one press event fires when db_cnt reaches DEBOUNCE_CYCLES-1.
//     A held button saturates and does not repeat.
//   - In manual mode, presses are ignored.
//   - A press outside HOLD is latched and served at the next HOLD.
//  disp_* change only on the CAPTURE edge, so the display never shows a half-updated value.
//  Reset mid-operation: returns to IDLE with all reset values on the same edge.
//   disp_valid drops to 0.
//  Counter widths: $clog2 of their parameter. Parameters must be >= 2.
// TESTING (REFRESH=8, DWELL=16, DEBOUNCE=4, rf model returns 0x1000_0000+addr)
//  1. Reset 3 cycles, manual, switch=5
//     -> reset outputs all 0; disp_addr=5, disp_value=0x1000_0005, disp_valid=1
//        by cycle 4 after reset release.
//  2. Manual steady at 5, rf model value changed to 0xDEAD_BEEF
//     -> re-read within 8+3 cycles; disp_value=0xDEAD_BEEF.
//  3. Switch 5->17 during HOLD at edge E
//     -> rf_dbg_addr=17 at E; disp_addr=17, disp_value=0x1000_0011 at E+2.
//  4. mode_auto=1 with switch=30
//     -> displays 30, 31, 0, 1, ... every 16+3 cycles.
//     Repeat with SKIP_R0=1 -> 31 is followed by 1.
//  5. Auto mode, step_btn high 3 cycles then bouncing, then high 10 cycles
//     -> exactly one advance; manual mode with the same stimulus -> no change.
//  6. Reset asserted in CAPTURE -> disp_valid=0, disp_value=0 next cycle;
//     normal capture resumes after release.

Source files
------------

// File: rtl/reg_debug_scan_ctrl.sv
// reg_debug_scan_ctrl
// Drives the register file debug read port for the board display. A manual
// source (register-select switches) and an auto scan over r0..r31 share the
// port. The scan is steppable by a debounced push button. Each read is
// captured into a stable display latch. The latch is refreshed periodically
// so the shown value follows the running pipeline.
module reg_debug_scan_ctrl #(
  parameter int REFRESH_CYCLES  = 1_000_000,
  parameter int DWELL_CYCLES    = 50_000_000,
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter bit SKIP_R0         = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  switch_register,
  input  logic        mode_auto,
  input  logic        step_btn,
  output logic [4:0]  rf_dbg_addr,
  input  logic [31:0] rf_dbg_data,
  output logic [4:0]  disp_addr,
  output logic [31:0] disp_value,
  output logic        disp_valid
);

  localparam int HOLD_MAX = (REFRESH_CYCLES > DWELL_CYCLES) ? REFRESH_CYCLES : DWELL_CYCLES;
  localparam int HOLD_W   = $clog2(HOLD_MAX);
  localparam int DB_W     = $clog2(DEBOUNCE_CYCLES);

  localparam logic [HOLD_W-1:0] REFRESH_LAST = HOLD_W'(REFRESH_CYCLES - 1);
  localparam logic [HOLD_W-1:0] DWELL_LAST   = HOLD_W'(DWELL_CYCLES - 1);
  localparam logic [DB_W-1:0]   DB_LAST      = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [4:0]        SCAN_FIRST   = SKIP_R0 ? 5'd1 : 5'd0;

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, HOLD} state_t;

  state_t            state;
  state_t            state_next;
  logic [4:0]        scan_addr;
  logic [4:0]        scan_next;
  logic [4:0]        target;
  logic              issue;
  logic              mode_q;
  logic [HOLD_W-1:0] hold_cnt;
  logic [DB_W-1:0]   db_cnt;
  logic              db_fired;
  logic              press_evt;
  logic              press_pending;
  logic              press_req;
  logic              press_take;

  // Next register in the scan order; r0 is skipped on wrap when requested.
  function automatic logic [4:0] scan_advance(input logic [4:0] a);
    return (a == 5'd31) ? SCAN_FIRST : a + 5'd1;
  endfunction

  // One press per run of DEBOUNCE_CYCLES high samples, never repeated while held.
  assign press_evt = step_btn && (db_cnt == DB_LAST) && !db_fired;
  assign press_req = press_pending || press_evt;

  // Next-state logic and the read target chosen for each new issue.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    target     = rf_dbg_addr;
    scan_next  = scan_addr;
    press_take = 1'b0;
    case (state)
      IDLE: begin
        issue  = 1'b1;
        target = mode_auto ? scan_addr : switch_register;
      end
      ISSUE:   state_next = CAPTURE;
      CAPTURE: state_next = HOLD;
      HOLD: begin
        if (mode_auto != mode_q) begin
          issue  = 1'b1;
          target = switch_register;
          if (mode_auto) scan_next = switch_register;
        end else if (!mode_auto && (switch_register != disp_addr)) begin
          issue  = 1'b1;
          target = switch_register;
        end else if (mode_auto && press_req) begin
          issue      = 1'b1;
          press_take = 1'b1;
          scan_next  = scan_advance(scan_addr);
          target     = scan_next;
        end else if (!mode_auto && (hold_cnt == REFRESH_LAST)) begin
          issue  = 1'b1;
          target = switch_register;
        end else if (mode_auto && (hold_cnt == DWELL_LAST)) begin
          issue     = 1'b1;
          scan_next = scan_advance(scan_addr);
          target    = scan_next;
        end
      end
      default: state_next = IDLE;
    endcase
    if (issue) state_next = ISSUE;
  end

  // State register, read address, scan pointer, hold timer and display latch.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rf_dbg_addr <= 5'd0;
      scan_addr   <= SCAN_FIRST;
      mode_q      <= 1'b0;
      hold_cnt    <= '0;
      disp_addr   <= 5'd0;
      disp_value  <= 32'd0;
      disp_valid  <= 1'b0;
    end else begin
      state     <= state_next;
      scan_addr <= scan_next;
      if (issue) begin
        rf_dbg_addr <= target;
        mode_q      <= mode_auto;
      end
      if (state == CAPTURE) begin
        disp_value <= rf_dbg_data;
        disp_addr  <= rf_dbg_addr;
        disp_valid <= 1'b1;
        hold_cnt   <= '0;
      end else if (state == HOLD) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Button debounce plus a pending flag so presses outside HOLD are not lost.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_cnt        <= '0;
      db_fired      <= 1'b0;
      press_pending <= 1'b0;
    end else begin
      if (!step_btn) begin
        db_cnt   <= '0;
        db_fired <= 1'b0;
      end else begin
        if (db_cnt != DB_LAST) db_cnt <= db_cnt + DB_W'(1);
        if (press_evt) db_fired <= 1'b1;
      end
      if (!mode_auto || press_take) press_pending <= 1'b0;
      else if (press_evt)           press_pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_reg_debug_scan_ctrl.sv
// Directed bench for reg_debug_scan_ctrl. Three instances share all inputs:
// the main one, one that skips r0 in the scan, and one with a long dwell so
// button steps can be observed without interference from dwell advances.
module tb_reg_debug_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  switch_register;
  logic        mode_auto;
  logic        step_btn;
  logic        override_en;

  logic [4:0]  addr_main, addr_skip, addr_long;
  logic [31:0] data_main, data_skip, data_long;
  logic [4:0]  daddr_main, daddr_skip, daddr_long;
  logic [31:0] dval_main, dval_skip, dval_long;
  logic        dvalid_main, dvalid_skip, dvalid_long;

  int checks = 0;
  int errors = 0;

  logic [4:0] exp_main [4] = '{5'd31, 5'd0, 5'd1, 5'd2};
  logic [4:0] exp_skip [4] = '{5'd31, 5'd1, 5'd2, 5'd3};

  // Register file model: every register reads 0x1000_0000 + index, except
  // r5 which can be overridden to show that refresh picks up new contents.
  function automatic logic [31:0] rf_model(input logic [4:0] a, input logic ovr);
    return (ovr && a == 5'd5) ? 32'hDEAD_BEEF : 32'h1000_0000 + {27'd0, a};
  endfunction

  assign data_main = rf_model(addr_main, override_en);
  assign data_skip = rf_model(addr_skip, override_en);
  assign data_long = rf_model(addr_long, override_en);

  always #5 clk = ~clk;

  reg_debug_scan_ctrl #(.REFRESH_CYCLES(8), .DWELL_CYCLES(16), .DEBOUNCE_CYCLES(4), .SKIP_R0(1'b0)) dut (
    .clk(clk), .reset(reset), .switch_register(switch_register), .mode_auto(mode_auto),
    .step_btn(step_btn), .rf_dbg_addr(addr_main), .rf_dbg_data(data_main),
    .disp_addr(daddr_main), .disp_value(dval_main), .disp_valid(dvalid_main));

  reg_debug_scan_ctrl #(.REFRESH_CYCLES(8), .DWELL_CYCLES(16), .DEBOUNCE_CYCLES(4), .SKIP_R0(1'b1)) dut_skip (
    .clk(clk), .reset(reset), .switch_register(switch_register), .mode_auto(mode_auto),
    .step_btn(step_btn), .rf_dbg_addr(addr_skip), .rf_dbg_data(data_skip),
    .disp_addr(daddr_skip), .disp_value(dval_skip), .disp_valid(dvalid_skip));

  reg_debug_scan_ctrl #(.REFRESH_CYCLES(8), .DWELL_CYCLES(1000), .DEBOUNCE_CYCLES(4), .SKIP_R0(1'b0)) dut_long (
    .clk(clk), .reset(reset), .switch_register(switch_register), .mode_auto(mode_auto),
    .step_btn(step_btn), .rf_dbg_addr(addr_long), .rf_dbg_data(data_long),
    .disp_addr(daddr_long), .disp_value(dval_long), .disp_valid(dvalid_long));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rst, input logic mode, input logic [4:0] sw);
    reset           = rst;
    mode_auto       = mode;
    switch_register = sw;
  endtask

  task automatic holdButton(input logic val, input int n);
    step_btn = val;
    for (int i = 0; i < n; i++) tick();
  endtask

  // Stimulus from the button scenario: a short burst, bouncing, then a long hold.
  task automatic buttonSequence();
    holdButton(1'b1, 3);
    holdButton(1'b0, 1);
    holdButton(1'b1, 1);
    holdButton(1'b0, 1);
    holdButton(1'b1, 2);
    holdButton(1'b0, 1);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    bit seen;
    logic [4:0] prev;

    override_en = 1'b0;
    step_btn    = 1'b0;

    // Reset for three cycles in manual mode with switch at r5.
    applyStimulus(1'b1, 1'b0, 5'd5);
    repeat (3) tick();
    checkOutput("reset_rf_addr", {27'd0, addr_main}, 32'd0);
    checkOutput("reset_disp_addr", {27'd0, daddr_main}, 32'd0);
    checkOutput("reset_disp_value", dval_main, 32'd0);
    checkOutput("reset_disp_valid", {31'd0, dvalid_main}, 32'd0);

    applyStimulus(1'b0, 1'b0, 5'd5);
    tick();
    checkOutput("first_issue_addr", {27'd0, addr_main}, 32'd5);
    checkOutput("valid_low_in_issue", {31'd0, dvalid_main}, 32'd0);
    tick();
    checkOutput("valid_low_in_capture", {31'd0, dvalid_main}, 32'd0);
    tick();
    checkOutput("first_disp_addr", {27'd0, daddr_main}, 32'd5);
    checkOutput("first_disp_value", dval_main, 32'h1000_0005);
    checkOutput("first_disp_valid", {31'd0, dvalid_main}, 32'd1);

    // Manual refresh picks up a changed register value.
    override_en = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (dval_main == 32'hDEAD_BEEF) seen = 1'b1;
    end
    checkOutput("refresh_value", dval_main, 32'hDEAD_BEEF);
    override_en = 1'b0;

    // Switch change in HOLD: address at E, display at E+2.
    applyStimulus(1'b0, 1'b0, 5'd17);
    tick();
    checkOutput("switch_rf_addr_E", {27'd0, addr_main}, 32'd17);
    checkOutput("switch_disp_old_E", {27'd0, daddr_main}, 32'd5);
    tick();
    checkOutput("switch_disp_old_E1", {27'd0, daddr_main}, 32'd5);
    tick();
    checkOutput("switch_disp_addr_E2", {27'd0, daddr_main}, 32'd17);
    checkOutput("switch_disp_value_E2", dval_main, 32'h1000_0011);

    // Auto scan starting at r30, with and without r0 in the sequence.
    applyStimulus(1'b0, 1'b1, 5'd30);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (daddr_main == 5'd30) seen = 1'b1;
    end
    checkOutput("auto_start_addr", {27'd0, daddr_main}, 32'd30);
    checkOutput("auto_start_skip_addr", {27'd0, daddr_skip}, 32'd30);
    for (int k = 0; k < 4; k++) begin
      prev = daddr_main;
      seen = 1'b0;
      for (int i = 0; i < 25 && !seen; i++) begin
        tick();
        if (daddr_main != prev) seen = 1'b1;
      end
      checkOutput($sformatf("scan_addr_%0d", k), {27'd0, daddr_main}, {27'd0, exp_main[k]});
      checkOutput($sformatf("scan_value_%0d", k), dval_main, 32'h1000_0000 + {27'd0, exp_main[k]});
      checkOutput($sformatf("scan_skip_addr_%0d", k), {27'd0, daddr_skip}, {27'd0, exp_skip[k]});
    end

    // Button stepping in auto mode on the long-dwell instance.
    applyStimulus(1'b0, 1'b0, 5'd10);
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (daddr_long == 5'd10) seen = 1'b1;
    end
    checkOutput("btn_manual_setup", {27'd0, daddr_long}, 32'd10);
    applyStimulus(1'b0, 1'b1, 5'd10);
    repeat (4) tick();
    checkOutput("btn_auto_setup", {27'd0, daddr_long}, 32'd10);
    buttonSequence();
    checkOutput("btn_bounce_no_step", {27'd0, daddr_long}, 32'd10);
    holdButton(1'b1, 10);
    holdButton(1'b0, 4);
    checkOutput("btn_one_step_addr", {27'd0, daddr_long}, 32'd11);
    checkOutput("btn_one_step_value", dval_long, 32'h1000_000B);
    repeat (10) tick();
    checkOutput("btn_no_repeat", {27'd0, daddr_long}, 32'd11);

    // Same button stimulus in manual mode must not move the display.
    applyStimulus(1'b0, 1'b0, 5'd11);
    repeat (4) tick();
    buttonSequence();
    holdButton(1'b1, 10);
    holdButton(1'b0, 4);
    checkOutput("btn_manual_ignored", {27'd0, daddr_long}, 32'd11);
    checkOutput("btn_manual_value", dval_long, 32'h1000_000B);

    // Reset while the main instance is in CAPTURE.
    applyStimulus(1'b0, 1'b0, 5'd12);
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      tick();
      if (addr_main == 5'd12) seen = 1'b1;
    end
    checkOutput("capture_issue_addr", {27'd0, addr_main}, 32'd12);
    tick();
    applyStimulus(1'b1, 1'b0, 5'd12);
    tick();
    checkOutput("midreset_valid", {31'd0, dvalid_main}, 32'd0);
    checkOutput("midreset_value", dval_main, 32'd0);
    checkOutput("midreset_disp_addr", {27'd0, daddr_main}, 32'd0);
    checkOutput("midreset_rf_addr", {27'd0, addr_main}, 32'd0);
    applyStimulus(1'b0, 1'b0, 5'd12);
    repeat (3) tick();
    checkOutput("resume_disp_addr", {27'd0, daddr_main}, 32'd12);
    checkOutput("resume_disp_value", dval_main, 32'h1000_000C);
    checkOutput("resume_disp_valid", {31'd0, dvalid_main}, 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
